// File: rtl/seg4_scan_driver_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan driver.
// Glyphs are active-low {a,b,c,d,e,f,g}.
package seg4_scan_driver_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] DIG_OFF = 4'hF;

  localparam logic [6:0] GLYPH_0 = 7'h01;
  localparam logic [6:0] GLYPH_1 = 7'h4F;
  localparam logic [6:0] GLYPH_2 = 7'h12;
  localparam logic [6:0] GLYPH_3 = 7'h06;
  localparam logic [6:0] GLYPH_4 = 7'h4C;
  localparam logic [6:0] GLYPH_5 = 7'h24;
  localparam logic [6:0] GLYPH_6 = 7'h20;
  localparam logic [6:0] GLYPH_7 = 7'h0F;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h04;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h60;
  localparam logic [6:0] GLYPH_C = 7'h31;
  localparam logic [6:0] GLYPH_D = 7'h42;
  localparam logic [6:0] GLYPH_E = 7'h30;
  localparam logic [6:0] GLYPH_F = 7'h38;

  // One display word: per-digit decimal points plus four hex nibbles.
  typedef struct packed {
    logic [3:0]  dp;
    logic [15:0] data;
  } disp_word_t;

endpackage

// File: rtl/seg4_scan_driver_if.sv
// Load-side bus of the scan driver: value/decimal-point capture strobe and the
// frame_start pulse returned to the upstream stage.
interface seg4_scan_driver_if;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        data_load;
  logic        frame_start;

  modport master (
    output data_in,
    output dp_in,
    output data_load,
    input  frame_start
  );

  modport slave (
    input  data_in,
    input  dp_in,
    input  data_load,
    output frame_start
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module hex_to_seg7
  import seg4_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_OFF;
    unique case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg4_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with frame-synchronous double buffering,
// per-slot anti-ghosting guard and optional leading-zero blanking.
module seg4_scan_driver
  import seg4_scan_driver_pkg::*;
#(
  parameter int unsigned DIG_PERIOD = 50000,
  parameter int unsigned GUARD      = 16,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic               FPGA_CLK,
  input  logic               RESET_BUT,
  seg4_scan_driver_if.slave  load_bus,
  output logic [6:0]         seg_n,
  output logic               dot_n,
  output logic [3:0]         dig_n
);

  localparam int unsigned CntW = (DIG_PERIOD > 1) ? $clog2(DIG_PERIOD) : 1;
  localparam logic [CntW-1:0] SlotLast = CntW'(DIG_PERIOD - 1);
  localparam logic [CntW-1:0] GuardCnt = CntW'(GUARD);

  logic [CntW-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]      dig_idx_q, dig_idx_d;
  disp_word_t      pend_q, pend_d;
  disp_word_t      disp_q, disp_d;
  logic            pend_vld_q, pend_vld_d;
  logic            frame_start_q, frame_start_d;
  logic [6:0]      seg_q, seg_d;
  logic            dot_q, dot_d;
  logic [3:0]      dig_q, dig_d;

  logic            slot_end;
  logic            frame_end;
  disp_word_t      load_word;
  logic [3:0]      cur_nibble;
  logic            cur_dp;
  logic [6:0]      cur_glyph;
  logic [3:0]      lz_vec;
  logic            in_guard;
  logic            blank;

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (cur_nibble),
    .glyph  (cur_glyph)
  );

  assign load_word = '{dp: load_bus.dp_in, data: load_bus.data_in};
  assign slot_end  = (slot_cnt_q == SlotLast);
  assign frame_end = slot_end && (dig_idx_q == 2'd3);

  // Slot timing and the pend -> disp double buffer.
  always_comb begin
    slot_cnt_d    = slot_end ? '0 : slot_cnt_q + 1'b1;
    dig_idx_d     = slot_end ? dig_idx_q + 2'd1 : dig_idx_q;
    pend_d        = pend_q;
    pend_vld_d    = pend_vld_q;
    disp_d        = disp_q;
    frame_start_d = 1'b0;
    if (frame_end) begin
      // A load on the boundary itself bypasses pend and lands in this frame.
      if (load_bus.data_load) begin
        disp_d = load_word;
      end else if (pend_vld_q) begin
        disp_d = pend_q;
      end
      frame_start_d = load_bus.data_load || pend_vld_q;
      pend_vld_d    = 1'b0;
    end else if (load_bus.data_load) begin
      pend_d     = load_word;
      pend_vld_d = 1'b1;
    end
  end

  // lz_vec[k]: nibbles k..3 and dp bits k..3 are all zero.
  always_comb begin
    lz_vec[3] = (disp_q.data[15:12] == 4'h0) && !disp_q.dp[3];
    lz_vec[2] = lz_vec[3] && (disp_q.data[11:8] == 4'h0) && !disp_q.dp[2];
    lz_vec[1] = lz_vec[2] && (disp_q.data[7:4] == 4'h0) && !disp_q.dp[1];
    lz_vec[0] = lz_vec[1] && (disp_q.data[3:0] == 4'h0) && !disp_q.dp[0];
  end

  always_comb begin
    cur_nibble = disp_q.data[{dig_idx_q, 2'b00} +: 4];
    cur_dp     = disp_q.dp[dig_idx_q];
    in_guard   = (slot_cnt_q < GuardCnt);
    blank      = BLANK_LZ && (dig_idx_q != 2'd0) && lz_vec[dig_idx_q];
    seg_d      = SEG_OFF;
    dot_d      = 1'b1;
    dig_d      = DIG_OFF;
    if (!in_guard) begin
      dig_d = ~(4'b0001 << dig_idx_q);
      if (!blank) begin
        seg_d = cur_glyph;
        dot_d = ~cur_dp;
      end
    end
  end

  always_ff @(posedge FPGA_CLK) begin
    if (RESET_BUT) begin
      slot_cnt_q    <= '0;
      dig_idx_q     <= 2'd0;
      pend_q        <= '0;
      disp_q        <= '0;
      pend_vld_q    <= 1'b0;
      frame_start_q <= 1'b0;
      seg_q         <= SEG_OFF;
      dot_q         <= 1'b1;
      dig_q         <= DIG_OFF;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      dig_idx_q     <= dig_idx_d;
      pend_q        <= pend_d;
      disp_q        <= disp_d;
      pend_vld_q    <= pend_vld_d;
      frame_start_q <= frame_start_d;
      seg_q         <= seg_d;
      dot_q         <= dot_d;
      dig_q         <= dig_d;
    end
  end

  assign seg_n                = seg_q;
  assign dot_n                = dot_q;
  assign dig_n                = dig_q;
  assign load_bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg4_scan_driver.sv
// Directed bench for seg4_scan_driver with DIG_PERIOD=8, GUARD=2 (32-clock frame).
module tb_seg4_scan_driver;

  logic       FPGA_CLK;
  logic       RESET_BUT;
  logic [6:0] seg_n;
  logic       dot_n;
  logic [3:0] dig_n;

  seg4_scan_driver_if bus ();

  seg4_scan_driver #(
    .DIG_PERIOD (8),
    .GUARD      (2),
    .BLANK_LZ   (1'b1)
  ) dut (
    .FPGA_CLK  (FPGA_CLK),
    .RESET_BUT (RESET_BUT),
    .load_bus  (bus),
    .seg_n     (seg_n),
    .dot_n     (dot_n),
    .dig_n     (dig_n)
  );

  initial FPGA_CLK = 1'b0;
  always #5 FPGA_CLK = ~FPGA_CLK;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [6:0]  seg [4];
    logic [3:0]  dot;
  } vec_t;

  vec_t vecs [7];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;  // edges since the last reset edge; internal slot position = cyc % 32
  int   fs_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge FPGA_CLK);
    #1;
    cyc++;
    if (bus.frame_start === 1'b1) fs_count++;
  endtask

  task automatic advance_to(input int pos);
    int n;
    n = 0;
    while ((cyc % 32) != pos && n < 64) begin
      tick();
      n++;
    end
    if ((cyc % 32) != pos) check("advance_to", 32'(cyc % 32), 32'(pos));
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p);
    bus.data_in   = d;
    bus.dp_in     = p;
    bus.data_load = 1'b1;
    tick();
    bus.data_load = 1'b0;
  endtask

  // Checks guard blanking, lit digit k with glyph/dot, and the slot's last clock.
  task automatic sample_digit(input int k, input logic [6:0] seg, input logic dot);
    logic [3:0] en;
    en = ~(4'b0001 << k);
    advance_to(8 * k + 2);
    check("guard_dig", 32'(dig_n), 32'hF);
    check("guard_seg", 32'(seg_n), 32'h7F);
    tick();
    check("slot_dig", 32'(dig_n), 32'(en));
    check("slot_seg", 32'(seg_n), 32'(seg));
    check("slot_dot", 32'(dot_n), 32'(dot));
    advance_to((8 * k + 8) % 32);
    check("slot_end_dig", 32'(dig_n), 32'(en));
    check("slot_end_seg", 32'(seg_n), 32'(seg));
  endtask

  task automatic set_vec(input int i, input logic [15:0] d, input logic [3:0] p,
                         input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3, input logic [3:0] dot);
    vecs[i].data   = d;
    vecs[i].dp     = p;
    vecs[i].seg[0] = s0;
    vecs[i].seg[1] = s1;
    vecs[i].seg[2] = s2;
    vecs[i].seg[3] = s3;
    vecs[i].dot    = dot;
  endtask

  initial begin
    // digit 0 (rightmost) first
    set_vec(0, 16'h1234, 4'b0000, 7'h4C, 7'h06, 7'h12, 7'h4F, 4'b1111);
    set_vec(1, 16'h0005, 4'b0000, 7'h24, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
    set_vec(2, 16'h0000, 4'b0000, 7'h01, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
    set_vec(3, 16'h00A0, 4'b0100, 7'h01, 7'h08, 7'h01, 7'h7F, 4'b1011);
    set_vec(4, 16'h89EF, 4'b1001, 7'h38, 7'h30, 7'h04, 7'h00, 4'b0110);
    set_vec(5, 16'h6B7C, 4'b0000, 7'h31, 7'h0F, 7'h60, 7'h20, 4'b1111);
    set_vec(6, 16'h0D00, 4'b0000, 7'h01, 7'h01, 7'h42, 7'h7F, 4'b1111);

    RESET_BUT     = 1'b1;
    bus.data_in   = 16'h0;
    bus.dp_in     = 4'h0;
    bus.data_load = 1'b0;

    // Reset and release
    repeat (3) tick();
    check("rst_seg", 32'(seg_n), 32'h7F);
    check("rst_dot", 32'(dot_n), 32'h1);
    check("rst_dig", 32'(dig_n), 32'hF);
    check("rst_fs", 32'(bus.frame_start), 32'h0);
    RESET_BUT = 1'b0;
    cyc       = 0;
    tick();
    check("rel_dig1", 32'(dig_n), 32'hF);
    tick();
    check("rel_dig2", 32'(dig_n), 32'hF);
    tick();
    check("rel_dig3", 32'(dig_n), 32'hE);

    // Table: load mid-frame, expect commit at the next boundary
    for (int i = 0; i < 7; i++) begin
      advance_to(10);
      load(vecs[i].data, vecs[i].dp);
      advance_to(0);
      check("vec_fs", 32'(bus.frame_start), 32'h1);
      for (int k = 0; k < 4; k++) sample_digit(k, vecs[i].seg[k], vecs[i].dot[k]);
    end

    // Tearing: load during digit 1's slot; rest of this frame keeps 0D00
    advance_to(8);
    fs_count = 0;
    load(16'h1111, 4'b0000);
    sample_digit(1, 7'h01, 1'b1);
    sample_digit(2, 7'h42, 1'b1);
    sample_digit(3, 7'h7F, 1'b1);
    sample_digit(0, 7'h4F, 1'b1);
    sample_digit(3, 7'h4F, 1'b1);
    check("tear_fs_count", 32'(fs_count), 32'd1);

    // Back-to-back loads: last value wins
    advance_to(10);
    fs_count = 0;
    load(16'hAAAA, 4'b0000);
    load(16'hBBBB, 4'b0000);
    for (int k = 0; k < 4; k++) sample_digit(k, 7'h60, 1'b1);
    check("b2b_fs_count", 32'(fs_count), 32'd1);

    // Load on the boundary cycle shows in the frame that starts right after it
    advance_to(31);
    load(16'h2468, 4'b0000);
    check("coinc_fs", 32'(bus.frame_start), 32'h1);
    sample_digit(0, 7'h00, 1'b1);
    sample_digit(1, 7'h20, 1'b1);
    sample_digit(2, 7'h4C, 1'b1);
    sample_digit(3, 7'h12, 1'b1);

    // Mid-scan reset while dig_idx = 2
    advance_to(19);
    check("pre_rst_dig", 32'(dig_n), 32'hB);
    RESET_BUT = 1'b1;
    tick();
    check("mid_rst_dig", 32'(dig_n), 32'hF);
    check("mid_rst_seg", 32'(seg_n), 32'h7F);
    check("mid_rst_dot", 32'(dot_n), 32'h1);
    RESET_BUT = 1'b0;
    cyc       = 0;
    sample_digit(0, 7'h01, 1'b1);
    sample_digit(1, 7'h7F, 1'b1);
    sample_digit(2, 7'h7F, 1'b1);
    sample_digit(3, 7'h7F, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
